// File: rtl/video_lcd_timing_if.sv
`default_nettype none
// ============================================================================
// Module   : video_lcd_timing_if
// Brief    : Pixel stream from the generator into the LCD timing stage.
// Revision : 1.0
// ============================================================================
interface video_lcd_timing_if #(
  parameter int pColorDepth = 16
);
  logic [pColorDepth-1:0] iPixel;
  logic                   iVd;
  logic                   oReady;

  // master = pixel generator, slave = LCD timing stage
  modport master (output iPixel, output iVd, input oReady);
  modport slave  (input iPixel, input iVd, output oReady);
endinterface
`default_nettype wire

// File: rtl/video_lcd_timing.sv
`default_nettype none
// ============================================================================
// Module   : video_lcd_timing
// Brief    : Pixel FIFO replayed to an LCD panel with run-time HSYNC/VSYNC/DE.
// Revision : 1.0
// ============================================================================
module video_lcd_timing #(
  parameter int pHdisplayWidth = 11,
  parameter int pVdisplayWidth = 11,
  parameter int pColorDepth    = 16,
  parameter int pFifoDepth     = 16
) (
  input  wire                      iClk,
  input  wire                      iRst,
  input  wire                      iCke,
  input  wire [pHdisplayWidth-1:0] iHdisplay,
  input  wire [pHdisplayWidth-1:0] iHfront,
  input  wire [pHdisplayWidth-1:0] iHsync,
  input  wire [pHdisplayWidth-1:0] iHback,
  input  wire [pVdisplayWidth-1:0] iVdisplay,
  input  wire [pVdisplayWidth-1:0] iVfront,
  input  wire [pVdisplayWidth-1:0] iVsync,
  input  wire [pVdisplayWidth-1:0] iVback,
  video_lcd_timing_if.slave        pixIf,
  output logic [pColorDepth-1:0]   oLcdPixel,
  output logic                     oDe,
  output logic                     oHsync,
  output logic                     oVsync,
  output logic                     oUnderflow
);

  localparam int cAddrW = $clog2(pFifoDepth);
  localparam int cCntW  = cAddrW + 1;
  localparam int cHsumW = pHdisplayWidth + 2;
  localparam int cVsumW = pVdisplayWidth + 2;

  localparam logic [cCntW-1:0]          cCntFull = cCntW'(pFifoDepth);
  localparam logic [cCntW-1:0]          cCntHalf = cCntW'(pFifoDepth / 2);
  localparam logic [cCntW-1:0]          cCntOne  = cCntW'(1);
  localparam logic [cAddrW-1:0]         cAddrOne = cAddrW'(1);
  localparam logic [pHdisplayWidth-1:0] cHone    = pHdisplayWidth'(1);
  localparam logic [pVdisplayWidth-1:0] cVone    = pVdisplayWidth'(1);
  localparam logic [cHsumW-1:0]         cHsumOne = cHsumW'(1);
  localparam logic [cVsumW-1:0]         cVsumOne = cVsumW'(1);

  typedef enum logic [0:0] {
    PREFILL = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t rState;
  state_t wStateNext;

  logic [pColorDepth-1:0]    rMem [pFifoDepth];
  logic [cAddrW-1:0]         rWrPtr;
  logic [cAddrW-1:0]         rRdPtr;
  logic [cCntW-1:0]          rCount;
  logic                      wReady;
  logic                      wPush;
  logic                      wPop;

  logic [pHdisplayWidth-1:0] rHcnt;
  logic [pVdisplayWidth-1:0] rVcnt;
  logic [cHsumW-1:0]         wHcntExt;
  logic [cVsumW-1:0]         wVcntExt;
  logic [cHsumW-1:0]         wHsyncStart;
  logic [cHsumW-1:0]         wHsyncEnd;
  logic [cHsumW-1:0]         wHtotal;
  logic [cVsumW-1:0]         wVsyncStart;
  logic [cVsumW-1:0]         wVsyncEnd;
  logic [cVsumW-1:0]         wVtotal;
  logic                      wHwrap;
  logic                      wVwrap;
  logic                      wDeC;
  logic                      wHsC;
  logic                      wVsC;

  logic                      wDeNext;
  logic                      wHsNext;
  logic                      wVsNext;
  logic                      wUnderflowSet;

  // Timing sums carry two extra bits so four full-scale fields cannot overflow.
  assign wHcntExt    = {2'b00, rHcnt};
  assign wVcntExt    = {2'b00, rVcnt};
  assign wHsyncStart = {2'b00, iHdisplay} + {2'b00, iHfront};
  assign wHsyncEnd   = wHsyncStart + {2'b00, iHsync};
  assign wHtotal     = wHsyncEnd + {2'b00, iHback};
  assign wVsyncStart = {2'b00, iVdisplay} + {2'b00, iVfront};
  assign wVsyncEnd   = wVsyncStart + {2'b00, iVsync};
  assign wVtotal     = wVsyncEnd + {2'b00, iVback};

  assign wHwrap = (wHcntExt == (wHtotal - cHsumOne));
  assign wVwrap = (wVcntExt == (wVtotal - cVsumOne));
  assign wDeC   = (rHcnt < iHdisplay) && (rVcnt < iVdisplay);
  assign wHsC   = (wHcntExt >= wHsyncStart) && (wHcntExt < wHsyncEnd);
  assign wVsC   = (wVcntExt >= wVsyncStart) && (wVcntExt < wVsyncEnd);

  assign wReady       = (rCount < cCntFull);
  assign pixIf.oReady = wReady;
  assign wPush        = pixIf.iVd && wReady;

  always_comb begin
    wStateNext    = rState;
    wDeNext       = 1'b0;
    wHsNext       = 1'b1;
    wVsNext       = 1'b1;
    wPop          = 1'b0;
    wUnderflowSet = 1'b0;
    case (rState)
      PREFILL: begin
        if (rCount >= cCntHalf) begin
          wStateNext = RUN;
        end
      end
      RUN: begin
        wDeNext       = wDeC;
        wHsNext       = ~wHsC;
        wVsNext       = ~wVsC;
        wPop          = wDeC && (rCount != '0);
        wUnderflowSet = wDeC && (rCount == '0);
      end
      default: wStateNext = PREFILL;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rState <= PREFILL;
    end else if (iCke) begin
      rState <= wStateNext;
    end
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge iClk) begin
    if (iCke && wPush) begin
      rMem[rWrPtr] <= pixIf.iPixel;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
    end else if (iCke) begin
      if (wPush) begin
        rWrPtr <= rWrPtr + cAddrOne;
      end
      if (wPop) begin
        rRdPtr <= rRdPtr + cAddrOne;
      end
      case ({wPush, wPop})
        2'b10:   rCount <= rCount + cCntOne;
        2'b01:   rCount <= rCount - cCntOne;
        default: rCount <= rCount;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rHcnt <= '0;
      rVcnt <= '0;
    end else if (iCke) begin
      if (rState != RUN) begin
        rHcnt <= '0;
        rVcnt <= '0;
      end else if (wHwrap) begin
        rHcnt <= '0;
        rVcnt <= wVwrap ? '0 : (rVcnt + cVone);
      end else begin
        rHcnt <= rHcnt + cHone;
      end
    end
  end

  // Pixel and sync outputs share one register stage so they stay aligned.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oLcdPixel  <= '0;
      oDe        <= 1'b0;
      oHsync     <= 1'b1;
      oVsync     <= 1'b1;
      oUnderflow <= 1'b0;
    end else if (iCke) begin
      oLcdPixel <= wPop ? rMem[rRdPtr] : '0;
      oDe       <= wDeNext;
      oHsync    <= wHsNext;
      oVsync    <= wVsNext;
      if (wUnderflowSet) begin
        oUnderflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_lcd_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_lcd_timing
// Brief    : Directed self-checking bench for video_lcd_timing.
// Revision : 1.0
// ============================================================================
module tb_video_lcd_timing;

  localparam int cHw = 11;
  localparam int cVw = 11;
  localparam int cCw = 16;
  localparam int cFd = 16;

  logic           iClk = 1'b0;
  logic           iRst = 1'b0;
  logic           iCke = 1'b1;
  logic [cHw-1:0] iHdisplay, iHfront, iHsync, iHback;
  logic [cVw-1:0] iVdisplay, iVfront, iVsync, iVback;
  logic [cCw-1:0] oLcdPixel;
  logic           oDe, oHsync, oVsync, oUnderflow;

  int   nTests = 0;
  int   nFail  = 0;
  int   pushed = 0;
  logic ckeToggle = 1'b0;

  video_lcd_timing_if #(.pColorDepth(cCw)) pixIf ();

  video_lcd_timing #(
    .pHdisplayWidth(cHw),
    .pVdisplayWidth(cVw),
    .pColorDepth   (cCw),
    .pFifoDepth    (cFd)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iCke      (iCke),
    .iHdisplay (iHdisplay),
    .iHfront   (iHfront),
    .iHsync    (iHsync),
    .iHback    (iHback),
    .iVdisplay (iVdisplay),
    .iVfront   (iVfront),
    .iVsync    (iVsync),
    .iVback    (iVback),
    .pixIf     (pixIf),
    .oLcdPixel (oLcdPixel),
    .oDe       (oDe),
    .oHsync    (oHsync),
    .oVsync    (oVsync),
    .oUnderflow(oUnderflow)
  );

  always #5 iClk = ~iClk;

  // One clock; upstream pixel advances only after an accepted write.
  task automatic tick();
    logic wp;
    wp = pixIf.iVd && pixIf.oReady && iCke;
    @(posedge iClk);
    #1;
    if (wp) begin
      pushed++;
      pixIf.iPixel = pixIf.iPixel + 16'd1;
    end
    if (ckeToggle) iCke = ~iCke;
  endtask

  task automatic doReset(input logic [cCw-1:0] base);
    iRst = 1'b0;
    pixIf.iVd = 1'b0;
    pixIf.iPixel = base;
    iCke = 1'b1;
    ckeToggle = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b1;
    pushed = 0;
  endtask

  task automatic runToDe(output int t8, output int tDe);
    t8 = -1;
    tDe = -1;
    pixIf.iVd = 1'b1;
    for (int k = 1; k <= 200 && tDe < 0; k++) begin
      tick();
      if (pushed == 8 && t8 < 0) t8 = k;
      if (oDe === 1'b1) tDe = k;
    end
  endtask

  task automatic test_reset();
    doReset(16'h0000);
    nTests++;
    if ({oDe, oHsync, oVsync, oUnderflow, pixIf.oReady} !== 5'b01101) begin
      nFail++;
      $display("FAIL reset_flags: got {de,hs,vs,uf,rdy}=%b want 01101",
               {oDe, oHsync, oVsync, oUnderflow, pixIf.oReady});
    end
    nTests++;
    if (oLcdPixel !== 16'h0000) begin
      nFail++;
      $display("FAIL reset_pixel: got %h want 0000", oLcdPixel);
    end
  endtask

  task automatic test_prefill();
    int t8, tDe, bad;
    doReset(16'h0100);
    bad = 0;
    repeat (40) begin
      tick();
      if (oDe !== 1'b0 || oHsync !== 1'b1 || oVsync !== 1'b1 || pixIf.oReady !== 1'b1) bad++;
    end
    nTests++;
    if (bad != 0) begin
      nFail++;
      $display("FAIL prefill_idle: got %0d non-idle cycles want 0", bad);
    end
    runToDe(t8, tDe);
    nTests++;
    if (t8 < 0 || tDe < 0 || (tDe - t8) != 2) begin
      nFail++;
      $display("FAIL prefill_latency: got %0d cycles want 2 (t8=%0d tDe=%0d)", tDe - t8, t8, tDe);
    end
    nTests++;
    if (oLcdPixel !== 16'h0100) begin
      nFail++;
      $display("FAIL prefill_first_pixel: got %h want 0100", oLcdPixel);
    end
  endtask

  task automatic test_timing();
    int t8, tDe, h, l, errDe, errHs, errVs, errPix, errUf;
    logic eDe, eHs, eVs;
    logic [cCw-1:0] expPix;
    doReset(16'h0000);
    runToDe(t8, tDe);
    nTests++;
    if (tDe < 0) begin
      nFail++;
      $display("FAIL timing_start: got no DE in 200 cycles want DE");
      return;
    end
    errDe = 0; errHs = 0; errVs = 0; errPix = 0; errUf = 0;
    expPix = 16'h0000;
    for (int t = 0; t < 128; t++) begin
      if (t > 0) tick();
      h = t % 16;
      l = (t / 16) % 8;
      eDe = (h < 8) && (l < 4);
      eHs = !((h >= 10) && (h < 13));
      eVs = !((l >= 5) && (l < 7));
      if (oDe !== eDe) errDe++;
      if (oHsync !== eHs) errHs++;
      if (oVsync !== eVs) errVs++;
      if (eDe) begin
        if (oLcdPixel !== expPix) errPix++;
        expPix = expPix + 16'd1;
      end
      if (oUnderflow !== 1'b0) errUf++;
    end
    nTests++;
    if (errDe != 0) begin nFail++; $display("FAIL timing_de: got %0d bad cycles want 0", errDe); end
    nTests++;
    if (errHs != 0) begin nFail++; $display("FAIL timing_hsync: got %0d bad cycles want 0", errHs); end
    nTests++;
    if (errVs != 0) begin nFail++; $display("FAIL timing_vsync: got %0d bad cycles want 0", errVs); end
    nTests++;
    if (errPix != 0) begin nFail++; $display("FAIL timing_pixels: got %0d bad pixels want 0", errPix); end
    nTests++;
    if (errUf != 0) begin nFail++; $display("FAIL timing_underflow: got %0d set cycles want 0", errUf); end
  endtask

  task automatic test_back_pressure();
    int t8, tDe, h, l, nOut, nLow, errLowDisp, errPix, errOcc;
    logic rdyAt20, rdyAt120;
    logic [cCw-1:0] expPix;
    doReset(16'h0000);
    runToDe(t8, tDe);
    nTests++;
    if (tDe < 0) begin
      nFail++;
      $display("FAIL bp_start: got no DE in 200 cycles want DE");
      return;
    end
    nOut = 0; nLow = 0; errLowDisp = 0; errPix = 0; errOcc = 0;
    rdyAt20 = 1'b0; rdyAt120 = 1'b1;
    expPix = 16'h0000;
    for (int t = 0; t < 384; t++) begin
      if (t > 0) tick();
      h = t % 16;
      l = (t / 16) % 8;
      if ((h < 8) && (l < 4)) begin
        if (oLcdPixel !== expPix) errPix++;
        expPix = expPix + 16'd1;
        nOut++;
      end
      if (pixIf.oReady === 1'b0) begin
        nLow++;
        if (l < 4 && h < 7) errLowDisp++;
      end
      if ((pushed - nOut) < 0 || (pushed - nOut) > cFd) errOcc++;
      if (t == 20) rdyAt20 = pixIf.oReady;
      if (t == 120) rdyAt120 = pixIf.oReady;
    end
    nTests++;
    if (errPix != 0) begin nFail++; $display("FAIL bp_scoreboard: got %0d bad pixels want 0", errPix); end
    nTests++;
    if (nLow == 0) begin nFail++; $display("FAIL bp_ready_falls: got %0d low cycles want >0", nLow); end
    nTests++;
    if (errLowDisp != 0) begin nFail++; $display("FAIL bp_ready_display: got %0d low in display want 0", errLowDisp); end
    nTests++;
    if (rdyAt20 !== 1'b1) begin nFail++; $display("FAIL bp_ready_line1: got %b want 1", rdyAt20); end
    nTests++;
    if (rdyAt120 !== 1'b0) begin nFail++; $display("FAIL bp_ready_full: got %b want 0", rdyAt120); end
    nTests++;
    if (errOcc != 0) begin nFail++; $display("FAIL bp_occupancy: got %0d bad cycles want 0", errOcc); end
  endtask

  task automatic test_underflow();
    int h, l, tDe, errDe, errPix, errEarly, errSticky;
    logic eDe, ufAt16, deAt16;
    logic [cCw-1:0] pixAt16, expPix;
    doReset(16'hA000);
    pixIf.iVd = 1'b1;
    for (int k = 0; k < 50 && pushed < 8; k++) tick();
    pixIf.iVd = 1'b0;
    tDe = -1;
    for (int k = 0; k < 10 && tDe < 0; k++) begin
      tick();
      if (oDe === 1'b1) tDe = k;
    end
    nTests++;
    if (tDe < 0) begin
      nFail++;
      $display("FAIL uf_start: got no DE in 10 cycles want DE");
      return;
    end
    errDe = 0; errPix = 0; errEarly = 0; errSticky = 0;
    ufAt16 = 1'b0; deAt16 = 1'b0; pixAt16 = 16'hFFFF;
    expPix = 16'hA000;
    for (int t = 0; t < 128; t++) begin
      if (t > 0) tick();
      h = t % 16;
      l = (t / 16) % 8;
      eDe = (h < 8) && (l < 4);
      if (oDe !== eDe) errDe++;
      if (t < 8) begin
        if (oLcdPixel !== expPix) errPix++;
        expPix = expPix + 16'd1;
      end else if (eDe && oLcdPixel !== 16'h0000) begin
        errPix++;
      end
      if (t < 16 && oUnderflow !== 1'b0) errEarly++;
      if (t == 16) begin
        ufAt16 = oUnderflow;
        deAt16 = oDe;
        pixAt16 = oLcdPixel;
      end
      if (t > 16 && oUnderflow !== 1'b1) errSticky++;
    end
    nTests++;
    if (errDe != 0) begin nFail++; $display("FAIL uf_de: got %0d bad cycles want 0", errDe); end
    nTests++;
    if (errPix != 0) begin nFail++; $display("FAIL uf_pixels: got %0d bad pixels want 0", errPix); end
    nTests++;
    if (errEarly != 0) begin nFail++; $display("FAIL uf_early: got %0d set cycles want 0", errEarly); end
    nTests++;
    if ({ufAt16, deAt16} !== 2'b11 || pixAt16 !== 16'h0000) begin
      nFail++;
      $display("FAIL uf_first_empty: got uf=%b de=%b pix=%h want uf=1 de=1 pix=0000", ufAt16, deAt16, pixAt16);
    end
    nTests++;
    if (errSticky != 0) begin nFail++; $display("FAIL uf_sticky: got %0d clear cycles want 0", errSticky); end
    doReset(16'h0000);
    nTests++;
    if (oUnderflow !== 1'b0) begin nFail++; $display("FAIL uf_reset_clear: got %b want 0", oUnderflow); end
  endtask

  task automatic test_cke();
    int t8, tDe, e, h, l, errEff, errHold;
    logic eDe, eHs, eVs;
    logic [cCw+2:0] prev;
    logic [cCw-1:0] expPix;
    doReset(16'h0000);
    ckeToggle = 1'b1;
    runToDe(t8, tDe);
    nTests++;
    if (t8 < 0 || tDe < 0 || (tDe - t8) != 4) begin
      nFail++;
      $display("FAIL cke_latency: got %0d cycles want 4 (t8=%0d tDe=%0d)", tDe - t8, t8, tDe);
    end
    errEff = 0; errHold = 0;
    expPix = 16'h0000;
    prev = '0;
    for (int t2 = 0; t2 < 256; t2++) begin
      if (t2 > 0) tick();
      if ((t2 % 2) == 0) begin
        e = t2 / 2;
        h = e % 16;
        l = (e / 16) % 8;
        eDe = (h < 8) && (l < 4);
        eHs = !((h >= 10) && (h < 13));
        eVs = !((l >= 5) && (l < 7));
        if (oDe !== eDe || oHsync !== eHs || oVsync !== eVs) errEff++;
        if (eDe) begin
          if (oLcdPixel !== expPix) errEff++;
          expPix = expPix + 16'd1;
        end
      end else if ({oDe, oHsync, oVsync, oLcdPixel} !== prev) begin
        errHold++;
      end
      prev = {oDe, oHsync, oVsync, oLcdPixel};
    end
    ckeToggle = 1'b0;
    iCke = 1'b1;
    nTests++;
    if (errEff != 0) begin nFail++; $display("FAIL cke_stretched: got %0d bad cycles want 0", errEff); end
    nTests++;
    if (errHold != 0) begin nFail++; $display("FAIL cke_hold: got %0d changed cycles want 0", errHold); end
  endtask

  task automatic test_reset_midline();
    int t8, tDe, errHs;
    logic eHs;
    doReset(16'h0000);
    runToDe(t8, tDe);
    repeat (37) tick();
    nTests++;
    if (oDe !== 1'b1) begin nFail++; $display("FAIL rst_pre_de: got %b want 1", oDe); end
    iRst = 1'b0;
    #1;
    nTests++;
    if ({oDe, oHsync, oVsync, pixIf.oReady, oUnderflow} !== 5'b01110 || oLcdPixel !== 16'h0000) begin
      nFail++;
      $display("FAIL rst_async: got {de,hs,vs,rdy,uf}=%b pix=%h want 01110 pix=0000",
               {oDe, oHsync, oVsync, pixIf.oReady, oUnderflow}, oLcdPixel);
    end
    doReset(16'h5000);
    runToDe(t8, tDe);
    nTests++;
    if (t8 < 0 || tDe < 0 || (tDe - t8) != 2) begin
      nFail++;
      $display("FAIL rst_reprefill: got %0d cycles want 2 (t8=%0d tDe=%0d)", tDe - t8, t8, tDe);
    end
    nTests++;
    if (oLcdPixel !== 16'h5000) begin nFail++; $display("FAIL rst_flush: got %h want 5000", oLcdPixel); end
    errHs = 0;
    for (int t = 1; t < 16; t++) begin
      tick();
      eHs = !((t >= 10) && (t < 13));
      if (oHsync !== eHs || oVsync !== 1'b1) errHs++;
    end
    nTests++;
    if (errHs != 0) begin nFail++; $display("FAIL rst_restart_line: got %0d bad cycles want 0", errHs); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iHdisplay = 11'd8;
    iHfront   = 11'd2;
    iHsync    = 11'd3;
    iHback    = 11'd3;
    iVdisplay = 11'd4;
    iVfront   = 11'd1;
    iVsync    = 11'd2;
    iVback    = 11'd1;
    pixIf.iVd = 1'b0;
    pixIf.iPixel = '0;
    test_reset();
    test_prefill();
    test_timing();
    test_back_pressure();
    test_underflow();
    test_cke();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_lcd_timing.md
# video_lcd_timing

Downstream stage of the pixel generator. It buffers the generator's pixel stream in a small FIFO and replays it to the LCD panel with HSYNC/VSYNC/DE timing built from run-time porch registers. It throttles the generator through a ready signal and flags underflow when the panel needs a pixel the FIFO does not have.

## Interface
- pHdisplayWidth, 11, width of all horizontal timing inputs and the H counter
- pVdisplayWidth, 11, width of all vertical timing inputs and the V counter
- pColorDepth, 16, pixel width
- pFifoDepth, 16, FIFO entries; power of two, ≥4

Ports:
- iClk  in  1  system clock; the block uses one clock only
- iRst  in  1  asynchronous, active-low reset
- iCke  in  1  clock enable; when low, all state holds, including counters, FIFO and outputs
- iHdisplay / iHfront / iHsync / iHback  in  pHdisplayWidth each  active pixels, front porch, sync width, back porch; all nonzero
- iVdisplay / iVfront / iVsync / iVback  in  pVdisplayWidth each  same fields in lines
- iPixel  in  pColorDepth  upstream pixel
- iVd  in  1  upstream pixel valid
- oReady  out  1  FIFO can accept a pixel; a write occurs on iVd & oReady & iCke
- oLcdPixel  out  pColorDepth  panel pixel
- oDe  out  1  data enable, active-high
- oHsync, oVsync  out  1  active-low sync
- oUnderflow  out  1  sticky underflow flag; cleared only by reset

## Operation
- FIFO:
  - Synchronous, pFifoDepth entries, with a count register of width log2(pFifoDepth)+1.
  - oReady = count < pFifoDepth (combinational from count).
  - A simultaneous push and pop leaves count unchanged.
  - A push while full is impossible because oReady gates it.
- State machine:
  - PREFILL (reset state): counters held at 0; outputs idle. Move to RUN when count ≥ pFifoDepth/2.
  - RUN: counters free-run. It never returns to PREFILL except through reset.
- H counter hcnt:
  - Counts 0 … Htotal−1, where Htotal = iHdisplay+iHfront+iHsync+iHback, computed at pHdisplayWidth+2 bits.
  - Wraps to 0 after Htotal−1. vcnt increments on that wrap.
- V counter vcnt: counts 0 … Vtotal−1 and wraps to 0 after Vtotal−1.
- Region order within each line and frame: display, front porch, sync, back porch.
- Decoded signals:
  - de_c = (hcnt < iHdisplay) & (vcnt < iVdisplay)
  - hs_c = hcnt ∈ [Hd+Hf, Hd+Hf+Hs)
  - vs_c = vcnt ∈ [Vd+Vf, Vd+Vf+Vs). VSYNC changes at line boundaries only, i.e. together with the hcnt 0 wrap.
- Pop and underflow in RUN:
  - A pop occurs when de_c is true and count > 0.
  - If de_c is true and count = 0: oLcdPixel = 0, DE stays asserted, and oUnderflow is set. The pixel is not retried.
- Timing input changes take effect immediately through the comparators. Software changes them only while the block is in reset.

## Timing
- Reset values (asserted asynchronously):
  - oLcdPixel=0, oDe=0, oHsync=1, oVsync=1, oUnderflow=0
  - FIFO count=0, so oReady=1 once reset is released
  - state=PREFILL, hcnt=vcnt=0
- Outputs are registered with one cycle of latency from counter decode. oDe, oHsync, oVsync and oLcdPixel are mutually aligned.
- Pop latency: the FIFO read data registered in the decode cycle appears on oLcdPixel in the same cycle oDe rises. This gives zero bubble between consecutive DE pixels.
- PREFILL→RUN: the first oDe rises 2 cycles after the write that makes count reach pFifoDepth/2 (1 cycle state update, 1 cycle output register).
- Line period is Htotal cycles; frame period is Htotal·Vtotal cycles (iCke high).
- Reset mid-frame:
  - Outputs return to reset values immediately and the FIFO is flushed.
  - After release, the block re-enters PREFILL and waits for a fresh prefill.
- A push and pop in the same cycle with count = pFifoDepth: oReady is low, so there is no push and only the pop occurs.

## Test plan
- Small timing (Hd=8, Hf=2, Hs=3, Hb=3; Vd=4, Vf=1, Vs=2, Vb=1), upstream always valid, pixel = incrementing count:
  - oDe high for 8 of every 16 cycles on lines 0–3 only.
  - oHsync low for cycles 10–12 of each line.
  - oVsync low on lines 5–6.
  - oLcdPixel sequence 0,1,2,… without gaps.
  - oUnderflow stays 0.
- Prefill, pFifoDepth=16: with iVd held low, oDe stays 0 and counters do not move. Push 8 pixels → first oDe exactly 2 cycles after the 8th write.
- Back-pressure: upstream always valid.
  - oReady falls when count=16 during blanking.
  - No pixel is lost or duplicated across 3 frames (scoreboard compare).
- Underflow: after RUN is reached, stop iVd.
  - The first DE cycle with empty FIFO outputs pixel 0 and sets oUnderflow=1.
  - oUnderflow stays 1 until reset.
- iCke toggling 1-0-1 every cycle: all outputs are identical to the iCke=1 run, stretched 2×.
- Reset mid-line (hcnt=5, line 2):
  - Immediately oDe=0, oHsync=oVsync=1, oReady=1.
  - After release, PREFILL repeats and output restarts at hcnt=vcnt=0.
